sop_lut_engine: RTL

- Parametrised, registered successor to the fixed gate-level sum-of-products function blocks.
- Holds N_FUNC programmable Boolean functions of N_IN inputs, each stored as a minterm mask.
- Evaluates all functions on an input vector with one-cycle latency.
- Provides an exhaustive sweep mode. The sweep streams the full truth table and reports the minterm count per function, for self-check against the lab truth tables.

---
 rtl/sop_lut_engine.sv | 103 ++++++++++
 1 files changed

// File: rtl/sop_lut_engine.sv
// Registered sum-of-products engine: N_FUNC programmable minterm masks over N_IN
// inputs, single-cycle evaluation, and an exhaustive truth-table sweep with minterm counts.
module sop_lut_engine #(
  parameter int N_IN   = 4,
  parameter int N_FUNC = 2,
  parameter int SEL_W  = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic [(2**N_IN)-1:0]       cfg_data,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_vec,
  output logic                       out_valid,
  output logic [N_FUNC-1:0]          out_y,
  output logic [N_IN-1:0]            out_idx,
  input  logic                       sweep_start,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic [N_FUNC*(N_IN+1)-1:0] sweep_cnt
);

  localparam int NT = 2**N_IN;
  localparam int CW = N_IN + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state, state_nx;
  logic [NT-1:0]     mask [N_FUNC];
  logic [N_IN-1:0]   idx;
  logic [N_IN-1:0]   eval_idx;
  logic [N_FUNC-1:0] eval_y;
  logic              accept, sweep_go, write_ok;

  always_comb begin
    in_ready   = (state == IDLE) && !sweep_start;
    accept     = in_valid && in_ready;
    sweep_go   = (state == IDLE) && sweep_start;
    write_ok   = cfg_we && in_ready && (32'(cfg_sel) < 32'(N_FUNC));
    sweep_busy = (state != IDLE);
    sweep_done = (state == DONE);
    // One lookup path shared by requests (IDLE) and the sweep walker (SWEEP).
    eval_idx   = (state == SWEEP) ? idx : in_vec;
    eval_y     = '0;
    for (int unsigned f = 0; f < N_FUNC; f++) begin
      eval_y[f] = mask[f][eval_idx];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sweep_start) state_nx = SWEEP;
      SWEEP:   if (idx == '1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned f = 0; f < N_FUNC; f++) mask[f] <= '0;
      idx       <= '0;
      sweep_cnt <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_idx   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !write_ok;
      for (int unsigned f = 0; f < N_FUNC; f++) begin
        if (write_ok && (cfg_sel == SEL_W'(f))) mask[f] <= cfg_data;
      end

      out_valid <= 1'b0;
      if (accept || (state == SWEEP)) begin
        out_valid <= 1'b1;
        out_idx   <= eval_idx;
        out_y     <= eval_y;
      end

      if (sweep_go) begin
        idx       <= '0;
        sweep_cnt <= '0;
      end else if (state == SWEEP) begin
        // idx wraps to 0 after the last minterm; CW bits hold a count of 2**N_IN.
        idx <= idx + 1'b1;
        for (int unsigned f = 0; f < N_FUNC; f++) begin
          sweep_cnt[f*CW +: CW] <= sweep_cnt[f*CW +: CW] + CW'(eval_y[f]);
        end
      end
    end
  end

endmodule
